// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO stream reader: burst FSM states and skid sizing.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Skid must absorb every word already requested (LATENCY of them) plus
  // two beats of slack so a stalled consumer never forces a bubble.
  function automatic int skid_depth(input int latency);
    return latency + 2;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Circular skid buffer holding FIFO read returns until the stream takes them.
// Latency: a pushed word is visible at head_data the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full.
module stream_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

  // Next pointers, storage and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array carries no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a burst of 'length' words from a fixed-latency FIFO onto a valid/ready stream.
// Latency: start -> pop request 1 cycle, pop -> data LATENCY cycles, data -> m_valid 1 cycle.
// Backpressure: credit-limited pops so m_ready stalls never overflow the skid buffer.
// Build option: define FIFO_STREAM_READER_TIMEOUT_EN to abort bursts stalled on an empty FIFO.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  input  logic             fifo_empty,
  output logic             fifo_request_output,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_output_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int SKID_DEPTH = skid_depth(LATENCY);
  localparam int CW         = $clog2(SKID_DEPTH + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [LATENCY-1:0] req_pipe_q, req_pipe_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;

  logic [CW-1:0]    skid_cnt;
  logic             skid_empty;
  logic [WIDTH-1:0] skid_head;
  logic             req, accept, credit_ok, out_ld;
  logic             skid_pop, skid_push, bypass, drain_ok, timeout_hit;

  // Words already requested count against the skid space they will land in.
  assign credit_ok = ((CW+1)'(skid_cnt) + (CW+1)'(inflight_q)) < (CW+1)'(SKID_DEPTH);
  assign req       = !rst && (state_q == ST_READ) && (remaining_q != '0) && !fifo_empty && credit_ok;
  // Returns are only meaningful for requests this burst actually issued.
  assign accept    = fifo_output_valid && (state_q != ST_IDLE) && (inflight_q != '0);

  // Output register refills when empty or when its beat is being taken.
  assign out_ld    = !m_valid_q || m_ready;
  assign skid_pop  = out_ld && !skid_empty;
  assign bypass    = out_ld && skid_empty && accept;
  assign skid_push = accept && !bypass;
  assign drain_ok  = (inflight_q == '0) && (req_pipe_q == '0) && skid_empty && out_ld;

  assign busy                = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done                = (state_q == ST_DONE);
  assign fifo_request_output = req;
  assign m_valid             = m_valid_q;
  assign m_data              = m_data_q;

  stream_skid_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .push_data (fifo_data_out),
    .pop       (skid_pop),
    .head_data (skid_head),
    .empty     (skid_empty),
    .count     (skid_cnt)
  );

`ifdef FIFO_STREAM_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q, to_flag_d;

  // Count consecutive empty READ cycles; any pop or non-empty cycle restarts it.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    if ((state_q == ST_IDLE) && start) to_flag_d = 1'b0;
    if ((state_q != ST_READ) || req || !fifo_empty) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    timeout_hit = (state_q == ST_READ) && (to_cnt_d == TW'(TIMEOUT));
    if (timeout_hit) to_flag_d = 1'b1;
  end

  // Stall counter and sticky abort flag reported alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign timed_out = (state_q == ST_DONE) && to_flag_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // Burst FSM, remaining-word count, in-flight tracking and stream output stage.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    inflight_d  = inflight_q;
    req_pipe_d  = LATENCY'({req_pipe_q, req});
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;

    if (req) remaining_d = remaining_q - 1'b1;

    case ({req, accept})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = length;
          state_d     = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (req && (remaining_q == LEN_W'(1))) state_d = ST_DRAIN;
        else if (timeout_hit)                  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_ok) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_ld) begin
      m_valid_d = !skid_empty || accept;
      if (!skid_empty) m_data_d = skid_head;
      else if (accept) m_data_d = fifo_data_out;
    end
  end

  // State registers; reset abandons any burst and drops returns still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      inflight_q  <= '0;
      req_pipe_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      req_pipe_q  <= req_pipe_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
    end
  end

endmodule
